if_stage: RTL and testbench

//  Instruction-fetch stage of the ARM pipeline: owns the PC register and drives
//  it to the combinational instruction memory. Registers the returned word plus
//  PC+4 into the IF/ID latch for decode. Supports hazard freeze, branch redirect

---
 rtl/if_stage.sv | 113 +++++++++++
 tb/tb_if_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, zero-latency IM address, IF/ID latch with freeze/branch flush.
// Optional RUN/HALT idle detection on the self-loop word is enabled by defining IF_HALT_DETECT_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] HALT_WORD = 32'hEAFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic [31:0] instruction_in,
    output logic [31:0] pc_to_im,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_pc_out;
    logic [31:0] r_instr;
    logic        r_valid;
    logic [31:0] r_count;

    logic [31:0] w_pc_next;
    logic [31:0] w_pc_out_next;
    logic [31:0] w_instr_next;
    logic        w_valid_next;
    logic [31:0] w_count_next;
    logic [31:0] w_pc_inc;
    logic        w_halt_hit;

    assign w_pc_inc = r_pc + PC_STEP;

`ifdef IF_HALT_DETECT_EN
    assign w_halt_hit = (instruction_in == HALT_WORD);
    assign halted     = (r_state == ST_HALT);
`else
    assign w_halt_hit = 1'b0;
    assign halted     = 1'b0;
`endif

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_pc_out_next = r_pc_out;
        w_instr_next  = r_instr;
        w_valid_next  = r_valid;
        w_count_next  = r_count;
        if (branch_taken) begin
            w_pc_next     = {branch_addr[31:2], 2'b00};
            w_pc_out_next = 32'd0;
            w_instr_next  = 32'd0;
            w_valid_next  = 1'b0;
            w_state_next  = ST_RUN;
        end else if (!freeze) begin
            case (r_state)
                ST_HALT: begin
                    w_pc_out_next = 32'd0;
                    w_instr_next  = 32'd0;
                    w_valid_next  = 1'b0;
                end
                default: begin
                    w_pc_out_next = w_pc_inc;
                    w_instr_next  = instruction_in;
                    w_valid_next  = 1'b1;
                    w_count_next  = r_count + 32'd1;
                    // The halt word is captured and counted, but PC parks on it.
                    if (w_halt_hit) begin
                        w_state_next = ST_HALT;
                    end else begin
                        w_pc_next = w_pc_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_pc     <= RESET_PC;
            r_pc_out <= 32'd0;
            r_instr  <= 32'd0;
            r_valid  <= 1'b0;
            r_count  <= 32'd0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_pc_out <= w_pc_out_next;
            r_instr  <= w_instr_next;
            r_valid  <= w_valid_next;
            r_count  <= w_count_next;
        end
    end

    assign pc_to_im        = r_pc;
    assign pc_out          = r_pc_out;
    assign instruction_out = r_instr;
    assign valid_out       = r_valid;
    assign fetch_count     = r_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; halt checks adapt to whether IF_HALT_DETECT_EN is defined.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] instruction_in;
    logic [31:0] pc_to_im;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;
    logic        halted;
    logic [31:0] fetch_count;

    int checks;
    int errors;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .instruction_in (instruction_in),
        .pc_to_im       (pc_to_im),
        .pc_out         (pc_out),
        .instruction_out(instruction_out),
        .valid_out      (valid_out),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a few fixed words, otherwise a recognisable address tag.
    function automatic logic [31:0] im_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: im_word = 32'hE3A00014;
            32'h0000_0004: im_word = 32'hE3A01A01;
            32'h0000_00B8: im_word = 32'hEAFFFFFF;
            default:       im_word = 32'hE1A00000 ^ a;
        endcase
    endfunction

    always_comb instruction_in = im_word(pc_to_im);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0;
        tick(); tick();
        checks++; if (pc_to_im !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_to_im, 32'd0); end
        checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc_out got %h exp %h", pc_out, 32'd0); end
        checks++; if (instruction_out !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp %h", instruction_out, 32'd0); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_out); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        tick();
        checks++; if (instruction_out !== 32'hE3A00014) begin errors++; $display("FAIL fetch0_instr got %h exp E3A00014", instruction_out); end
        checks++; if (pc_out !== 32'd4) begin errors++; $display("FAIL fetch0_pc_out got %h exp 4", pc_out); end
        tick();
        checks++; if (pc_to_im !== 32'd8) begin errors++; $display("FAIL fetch_pc got %h exp 8", pc_to_im); end
        checks++; if (instruction_out !== 32'hE3A01A01) begin errors++; $display("FAIL fetch_instr got %h exp E3A01A01", instruction_out); end
        checks++; if (pc_out !== 32'd8) begin errors++; $display("FAIL fetch_pc_out got %h exp 8", pc_out); end
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL fetch_valid got %b exp 1", valid_out); end
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL fetch_count got %0d exp 2", fetch_count); end
    endtask

    task automatic test_freeze();
        tick();
        checks++; if (pc_to_im !== 32'd12) begin errors++; $display("FAIL pre_freeze_pc got %h exp c", pc_to_im); end
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc_to_im !== 32'd12) begin errors++; $display("FAIL freeze_pc[%0d] got %h exp c", i, pc_to_im); end
            checks++; if (instruction_out !== 32'hE1A00008 || pc_out !== 32'd12) begin errors++; $display("FAIL freeze_ifid[%0d] got %h/%h exp E1A00008/c", i, instruction_out, pc_out); end
            checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL freeze_count[%0d] got %0d exp 3", i, fetch_count); end
        end
        freeze = 1'b0;
        tick();
        checks++; if (instruction_out !== 32'hE1A0000C) begin errors++; $display("FAIL unfreeze_instr got %h exp E1A0000C", instruction_out); end
        checks++; if (pc_out !== 32'd16 || pc_to_im !== 32'd16) begin errors++; $display("FAIL unfreeze_pc got %h/%h exp 10/10", pc_out, pc_to_im); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL unfreeze_count got %0d exp 4", fetch_count); end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; branch_addr = 32'h70; freeze = 1'b1;
        tick();
        branch_taken = 1'b0; freeze = 1'b0;
        checks++; if (pc_to_im !== 32'h70) begin errors++; $display("FAIL branch_pc got %h exp 70", pc_to_im); end
        checks++; if (valid_out !== 1'b0 || instruction_out !== 32'd0 || pc_out !== 32'd0) begin errors++; $display("FAIL branch_flush got %b/%h/%h exp 0/0/0", valid_out, instruction_out, pc_out); end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL branch_count got %0d exp 4", fetch_count); end
        tick();
        checks++; if (instruction_out !== 32'hE1A00070 || pc_out !== 32'h74 || valid_out !== 1'b1) begin errors++; $display("FAIL branch_target got %h/%h/%b exp E1A00070/74/1", instruction_out, pc_out, valid_out); end
        checks++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL branch_target_count got %0d exp 5", fetch_count); end
    endtask

    task automatic test_branch_align();
        branch_taken = 1'b1; branch_addr = 32'h73;
        tick();
        branch_taken = 1'b0;
        checks++; if (pc_to_im !== 32'h70) begin errors++; $display("FAIL align_pc got %h exp 70", pc_to_im); end
    endtask

    task automatic test_halt();
        branch_taken = 1'b1; branch_addr = 32'hB4;
        tick();
        branch_taken = 1'b0;
        tick();
        checks++; if (pc_to_im !== 32'hB8 || fetch_count !== 32'd6) begin errors++; $display("FAIL pre_halt got %h/%0d exp b8/6", pc_to_im, fetch_count); end
        tick();
        checks++; if (instruction_out !== 32'hEAFFFFFF || valid_out !== 1'b1 || pc_out !== 32'hBC) begin errors++; $display("FAIL halt_capture got %h/%b/%h exp EAFFFFFF/1/bc", instruction_out, valid_out, pc_out); end
        checks++; if (fetch_count !== 32'd7) begin errors++; $display("FAIL halt_capture_count got %0d exp 7", fetch_count); end
`ifdef IF_HALT_DETECT_EN
        checks++; if (halted !== 1'b1 || pc_to_im !== 32'hB8) begin errors++; $display("FAIL halt_enter got %b/%h exp 1/b8", halted, pc_to_im); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (valid_out !== 1'b0 || instruction_out !== 32'd0 || pc_to_im !== 32'hB8 || fetch_count !== 32'd7 || halted !== 1'b1) begin
                errors++; $display("FAIL halt_hold[%0d] got v%b i%h pc%h n%0d h%b exp v0 i0 pcb8 n7 h1", i, valid_out, instruction_out, pc_to_im, fetch_count, halted);
            end
        end
        branch_taken = 1'b1; branch_addr = 32'd0;
        tick();
        branch_taken = 1'b0;
        checks++; if (halted !== 1'b0 || pc_to_im !== 32'd0) begin errors++; $display("FAIL halt_exit got %b/%h exp 0/0", halted, pc_to_im); end
`else
        checks++; if (halted !== 1'b0 || pc_to_im !== 32'hBC) begin errors++; $display("FAIL nohalt_adv got %b/%h exp 0/bc", halted, pc_to_im); end
        tick();
        checks++; if (instruction_out !== 32'hE1A000BC || valid_out !== 1'b1 || fetch_count !== 32'd8) begin errors++; $display("FAIL nohalt_next got %h/%b/%0d exp E1A000BC/1/8", instruction_out, valid_out, fetch_count); end
`endif
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_addr = 32'hFFFFFFFC;
        tick();
        branch_taken = 1'b0;
        checks++; if (pc_to_im !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_start got %h exp fffffffc", pc_to_im); end
        tick();
        checks++; if (pc_to_im !== 32'd0 || pc_out !== 32'd0) begin errors++; $display("FAIL wrap_pc got %h/%h exp 0/0", pc_to_im, pc_out); end
        checks++; if (instruction_out !== 32'h1E5FFFFC || valid_out !== 1'b1) begin errors++; $display("FAIL wrap_instr got %h/%b exp 1E5FFFFC/1", instruction_out, valid_out); end
    endtask

    task automatic test_reset_mid_halt();
        branch_taken = 1'b1; branch_addr = 32'hB8;
        tick();
        branch_taken = 1'b0;
        tick();
`ifdef IF_HALT_DETECT_EN
        checks++; if (halted !== 1'b1 || pc_to_im !== 32'hB8) begin errors++; $display("FAIL rehalt got %b/%h exp 1/b8", halted, pc_to_im); end
`endif
        rst = 1'b1; freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h40;
        tick();
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
        checks++; if (pc_to_im !== 32'd0 || pc_out !== 32'd0 || instruction_out !== 32'd0) begin errors++; $display("FAIL midrst_regs got %h/%h/%h exp 0/0/0", pc_to_im, pc_out, instruction_out); end
        checks++; if (valid_out !== 1'b0 || halted !== 1'b0 || fetch_count !== 32'd0) begin errors++; $display("FAIL midrst_flags got %b/%b/%0d exp 0/0/0", valid_out, halted, fetch_count); end
        tick();
        checks++; if (instruction_out !== 32'hE3A00014 || fetch_count !== 32'd1) begin errors++; $display("FAIL post_rst got %h/%0d exp E3A00014/1", instruction_out, fetch_count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fetch();
        test_freeze();
        test_branch();
        test_branch_align();
        test_halt();
        test_wrap();
        test_reset_mid_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
